preamble_ctrl: RTL and testbench
================================

PREAMBLE_CTRL -- requirements
Module: preamble_ctrl

Interface
REQ-001 Parameter RESET_HOLD, default 2: clocks the downstream detector reset is held on entry to SHORT or LONG; legal range 1..15.
REQ-002 clock  input  1  sole clock; all logic on rising edge.
REQ-003 reset  input  1  synchronous, active-high.
REQ-004 enable  input  1  global advance qualifier.
REQ-005 sample_in_strobe  input  1  one pulse per input sample.
REQ-006 power_trigger  input  1  level; high while received power exceeds threshold.
REQ-007 short_preamble_detected  input  1  single-cycle pulse from short-preamble detector.
REQ-008 phase_offset_in  input  16  signed per-sample phase offset from short-preamble detector.
REQ-009 long_preamble_detected  input  1  single-cycle pulse from long-preamble detector.
REQ-010 long_timeout  input  32  LONG search window in samples; 0 disables the timeout.
REQ-011 decode_done  input  1  pulse; downstream header/payload finished.
REQ-012 abort  input  1  pulse; downstream requests immediate return to idle.
REQ-013 sync_short_reset / sync_short_enable  output  1 each  control of the short-preamble detector.
REQ-014 sync_long_reset / sync_long_enable  output  1 each  control of the long-preamble detector.
REQ-015 phase_offset  output  16  signed; offset latched at short-preamble detection.
REQ-016 sync_ok / sync_fail  output  1 each  single-cycle status pulses.
REQ-017 state  output  3  encoding IDLE=0, SHORT=1, LONG=2, DECODE=3.

Function
REQ-018 All outputs SHALL be registered; every transition below takes effect one clock after the qualifying input cycle.
REQ-019 All state, counter and latch updates SHALL occur only when enable=1; with enable=0, state, counters and phase_offset hold, and sync_short_enable, sync_long_enable, sync_ok and sync_fail are 0.
REQ-020 IDLE -> SHORT when power_trigger=1.
REQ-021 On every entry to SHORT, a hold counter SHALL load RESET_HOLD.
  - sync_short_reset=1 and sync_short_enable=0 while hold>0.
  - Then sync_short_reset=0 and sync_short_enable=1.
REQ-022 short_preamble_detected SHALL be ignored while hold>0 and in every state other than SHORT.
REQ-023 SHORT, detection accepted: latch phase_offset_in into phase_offset; go to LONG.
REQ-024 SHORT: power_trigger=0 coincident with sample_in_strobe -> IDLE; detection SHALL take priority over this exit.
REQ-025 On entry to LONG, the following SHALL occur:
  - Hold counter loads RESET_HOLD; sync_long_reset=1 and sync_long_enable=0 while hold>0.
  - 32-bit sample counter clears; it counts sample_in_strobe only after hold reaches 0.
  - sync_short_enable=0.
REQ-026 LONG, long_preamble_detected with hold=0: pulse sync_ok; go to DECODE.
REQ-027 LONG timeout: when long_timeout!=0 and the counter reaches long_timeout on a strobe:
  - Pulse sync_fail.
  - Re-enter SHORT, restarting its reset hold.
REQ-028 If detection and timeout occur in the same cycle, detection SHALL win: sync_ok only, no sync_fail.
REQ-029 DECODE: both detectors SHALL be disabled and not in reset; decode_done -> IDLE.
REQ-030 abort SHALL take highest priority in every state: next state IDLE, no sync_ok/sync_fail pulse, phase_offset retained.
REQ-031 In IDLE, both resets SHALL be 1 and both enables 0.
REQ-032 The sample counter SHALL saturate at 0xFFFFFFFF and not wrap.
REQ-033 phase_offset SHALL change only on an accepted short detection.

Reset
REQ-034 reset SHALL dominate enable and all inputs and apply at any state, including mid-LONG.
REQ-035 Reset values SHALL be:
  - state=IDLE; hold and sample counters 0; phase_offset=0.
  - sync_ok=0, sync_fail=0.
  - sync_short_reset=1, sync_long_reset=1, both enables 0.

Verification
REQ-036 Bench SHALL cover the nominal path: power_trigger=1, short pulse with phase_offset_in=-9 after hold, long pulse at sample 40 (long_timeout=160) -> state 0->1->2->3, phase_offset=-9, one sync_ok, no sync_fail; decode_done -> state 0.
REQ-037 Bench SHALL cover the reset hold: RESET_HOLD=2, short pulse during hold cycle 1 -> ignored, state stays 1; sync_short_reset high exactly 2 clocks.
REQ-038 Bench SHALL cover the timeout: long_timeout=160, no long pulse -> one sync_fail on the 160th counted strobe, state returns to 1, sync_short_reset reasserted 2 clocks.
REQ-039 Bench SHALL cover the simultaneous case: long pulse on the 160th strobe -> sync_ok=1, sync_fail=0, state 3.
REQ-040 Bench SHALL cover abort and reset mid-LONG: abort -> state 0, no pulses, phase_offset retained; reset mid-LONG -> all REQ-035 values next clock.
REQ-041 Bench SHALL cover enable gating: enable=0 for 10 clocks in LONG -> counter, state and phase_offset frozen, enables 0; resume continues count from the frozen value.

Source files
------------

// File: rtl/preamble_ctrl.sv
// preamble_ctrl: sequences the short- and long-preamble detectors of a
// receiver front end (IDLE -> SHORT -> LONG -> DECODE), generating their
// reset/enable controls, latching the short-preamble phase offset and
// reporting sync success or failure as single-cycle pulses.
module preamble_ctrl #(
  parameter int RESET_HOLD = 2
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               enable,
  input  logic               sample_in_strobe,
  input  logic               power_trigger,
  input  logic               short_preamble_detected,
  input  logic signed [15:0] phase_offset_in,
  input  logic               long_preamble_detected,
  input  logic [31:0]        long_timeout,
  input  logic               decode_done,
  input  logic               abort,
  output logic               sync_short_reset,
  output logic               sync_short_enable,
  output logic               sync_long_reset,
  output logic               sync_long_enable,
  output logic signed [15:0] phase_offset,
  output logic               sync_ok,
  output logic               sync_fail,
  output logic [2:0]         state
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SHORT  = 3'd1,
    ST_LONG   = 3'd2,
    ST_DECODE = 3'd3
  } state_t;

  localparam logic [3:0]  HOLD_INIT = 4'(RESET_HOLD);
  localparam logic [31:0] COUNT_MAX = 32'hFFFF_FFFF;

  state_t             state_q, state_d;
  logic [3:0]         hold_q, hold_d;
  logic [31:0]        count_q, count_d;
  logic signed [15:0] phase_d;
  logic               ok_d, fail_d;

  logic        hold_zero;
  logic        counted_strobe;
  logic [31:0] count_inc;

  assign hold_zero      = (hold_q == 4'd0);
  assign counted_strobe = hold_zero && sample_in_strobe;
  // Sample counter sticks at all-ones instead of wrapping.
  assign count_inc      = (count_q == COUNT_MAX) ? count_q : count_q + 32'd1;

  // Next-state, counter and latch logic; nothing advances without enable.
  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // leaves a variable unassigned, which would otherwise infer a latch.
    state_d = state_q;
    hold_d  = hold_q;
    count_d = count_q;
    phase_d = phase_offset;
    ok_d    = 1'b0;
    fail_d  = 1'b0;

    if (enable) begin
      if (abort) begin
        state_d = ST_IDLE;
        hold_d  = 4'd0;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (power_trigger) begin
              state_d = ST_SHORT;
              hold_d  = HOLD_INIT;
            end
          end
          ST_SHORT: begin
            // Accepted detection beats the loss-of-power exit.
            if (hold_zero && short_preamble_detected) begin
              phase_d = phase_offset_in;
              state_d = ST_LONG;
              hold_d  = HOLD_INIT;
              count_d = 32'd0;
            end else if (sample_in_strobe && !power_trigger) begin
              state_d = ST_IDLE;
              hold_d  = 4'd0;
            end else if (!hold_zero) begin
              hold_d = hold_q - 4'd1;
            end
          end
          ST_LONG: begin
            // Detection beats a timeout landing on the same strobe.
            if (hold_zero && long_preamble_detected) begin
              ok_d    = 1'b1;
              state_d = ST_DECODE;
            end else if (counted_strobe) begin
              count_d = count_inc;
              if ((long_timeout != 32'd0) && (count_inc == long_timeout)) begin
                fail_d  = 1'b1;
                state_d = ST_SHORT;
                hold_d  = HOLD_INIT;
              end
            end else if (!hold_zero) begin
              hold_d = hold_q - 4'd1;
            end
          end
          ST_DECODE: begin
            if (decode_done) begin
              state_d = ST_IDLE;
            end
          end
          default: begin
            state_d = ST_IDLE;
            hold_d  = 4'd0;
          end
        endcase
      end
    end
  end

  // Detector controls are decoded from the next state so they can be
  // registered alongside it.
  logic short_rst_d, short_en_d, long_rst_d, long_en_d;

  assign short_rst_d = (state_d == ST_IDLE) || ((state_d == ST_SHORT) && (hold_d != 4'd0));
  assign long_rst_d  = (state_d == ST_IDLE) || ((state_d == ST_LONG)  && (hold_d != 4'd0));
  assign short_en_d  = enable && (state_d == ST_SHORT) && (hold_d == 4'd0);
  assign long_en_d   = enable && (state_d == ST_LONG)  && (hold_d == 4'd0);

  // State, counters and all registered outputs with synchronous reset.
  always_ff @(posedge clock) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples values from before the edge.
    if (reset) begin
      state_q           <= ST_IDLE;
      hold_q            <= 4'd0;
      count_q           <= 32'd0;
      phase_offset      <= 16'sd0;
      sync_ok           <= 1'b0;
      sync_fail         <= 1'b0;
      sync_short_reset  <= 1'b1;
      sync_short_enable <= 1'b0;
      sync_long_reset   <= 1'b1;
      sync_long_enable  <= 1'b0;
    end else begin
      state_q           <= state_d;
      hold_q            <= hold_d;
      count_q           <= count_d;
      phase_offset      <= phase_d;
      sync_ok           <= ok_d;
      sync_fail         <= fail_d;
      sync_short_reset  <= short_rst_d;
      sync_short_enable <= short_en_d;
      sync_long_reset   <= long_rst_d;
      sync_long_enable  <= long_en_d;
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_preamble_ctrl.sv
// tb_preamble_ctrl: directed stimulus for preamble_ctrl, checked every cycle
// against a behavioural model of the sync sequence plus literal expectations.
module tb_preamble_ctrl;

  localparam int RH = 2;

  logic        clock = 1'b0;
  logic        reset;
  logic        enable;
  logic        sample_in_strobe;
  logic        power_trigger;
  logic        short_preamble_detected;
  logic [15:0] phase_offset_in;
  logic        long_preamble_detected;
  logic [31:0] long_timeout;
  logic        decode_done;
  logic        abort;
  logic        sync_short_reset, sync_short_enable;
  logic        sync_long_reset, sync_long_enable;
  logic [15:0] phase_offset;
  logic        sync_ok, sync_fail;
  logic [2:0]  state;

  preamble_ctrl #(.RESET_HOLD(RH)) dut (
    .clock                   (clock),
    .reset                   (reset),
    .enable                  (enable),
    .sample_in_strobe        (sample_in_strobe),
    .power_trigger           (power_trigger),
    .short_preamble_detected (short_preamble_detected),
    .phase_offset_in         (phase_offset_in),
    .long_preamble_detected  (long_preamble_detected),
    .long_timeout            (long_timeout),
    .decode_done             (decode_done),
    .abort                   (abort),
    .sync_short_reset        (sync_short_reset),
    .sync_short_enable       (sync_short_enable),
    .sync_long_reset         (sync_long_reset),
    .sync_long_enable        (sync_long_enable),
    .phase_offset            (phase_offset),
    .sync_ok                 (sync_ok),
    .sync_fail               (sync_fail),
    .state                   (state)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int ok_cnt = 0;
  int fail_cnt = 0;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Behavioural model: mode 0..3, remaining hold clocks, samples seen in
  // the long search window, latched offset and the pulses due this cycle.
  bit          m_valid = 0;
  int          m_mode = 0;
  int          m_hold_left = 0;
  longint      m_samples = 0;
  logic [15:0] m_phase = 16'h0;
  bit          m_ok = 0, m_fail = 0, m_en = 0;

  always @(posedge clock) begin
    m_valid = 1;
    m_ok    = 0;
    m_fail  = 0;
    if (reset) begin
      m_mode = 0; m_hold_left = 0; m_samples = 0; m_phase = 16'h0; m_en = 0;
    end else begin
      m_en = enable;
      if (!enable) begin
        // frozen
      end else if (abort) begin
        m_mode = 0; m_hold_left = 0;
      end else if (m_mode == 0) begin
        if (power_trigger) begin m_mode = 1; m_hold_left = RH; end
      end else if (m_mode == 1) begin
        if (m_hold_left == 0 && short_preamble_detected) begin
          m_phase = phase_offset_in; m_mode = 2; m_hold_left = RH; m_samples = 0;
        end else if (sample_in_strobe && !power_trigger) begin
          m_mode = 0; m_hold_left = 0;
        end else if (m_hold_left > 0) begin
          m_hold_left--;
        end
      end else if (m_mode == 2) begin
        if (m_hold_left > 0) begin
          m_hold_left--;
        end else if (long_preamble_detected) begin
          m_ok = 1; m_mode = 3;
        end else if (sample_in_strobe) begin
          if (m_samples < 64'hFFFF_FFFF) m_samples++;
          if (long_timeout != 0 && m_samples == longint'(long_timeout)) begin
            m_fail = 1; m_mode = 1; m_hold_left = RH;
          end
        end
      end else begin
        if (decode_done) m_mode = 0;
      end
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  always @(negedge clock) begin
    if (m_valid) begin
      check("m_state", {29'b0, state}, 32'(m_mode));
      check("m_short_reset", {31'b0, sync_short_reset}, {31'b0, (m_mode == 0) || (m_mode == 1 && m_hold_left > 0)});
      check("m_long_reset", {31'b0, sync_long_reset}, {31'b0, (m_mode == 0) || (m_mode == 2 && m_hold_left > 0)});
      check("m_short_enable", {31'b0, sync_short_enable}, {31'b0, m_en && m_mode == 1 && m_hold_left == 0});
      check("m_long_enable", {31'b0, sync_long_enable}, {31'b0, m_en && m_mode == 2 && m_hold_left == 0});
      check("m_phase", {16'b0, phase_offset}, {16'b0, m_phase});
      check("m_ok", {31'b0, sync_ok}, {31'b0, m_ok});
      check("m_fail", {31'b0, sync_fail}, {31'b0, m_fail});
      if (sync_ok === 1'b1) ok_cnt++;
      if (sync_fail === 1'b1) fail_cnt++;
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic strobes(input int n);
    for (int i = 0; i < n; i++) begin
      sample_in_strobe = 1'b1;
      tick();
    end
    sample_in_strobe = 1'b0;
  endtask

  // From IDLE with power present: through the short hold, accept a short
  // detection carrying p, then run out the long hold.
  task automatic to_long(input logic [15:0] p);
    tick(); tick(); tick();
    short_preamble_detected = 1'b1;
    phase_offset_in = p;
    tick();
    short_preamble_detected = 1'b0;
    tick(); tick();
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"}, {29'b0, state}, 32'd0);
    check({tag, "_short_reset"}, {31'b0, sync_short_reset}, 32'd1);
    check({tag, "_long_reset"}, {31'b0, sync_long_reset}, 32'd1);
    check({tag, "_short_enable"}, {31'b0, sync_short_enable}, 32'd0);
    check({tag, "_long_enable"}, {31'b0, sync_long_enable}, 32'd0);
    check({tag, "_phase"}, {16'b0, phase_offset}, 32'd0);
    check({tag, "_ok"}, {31'b0, sync_ok}, 32'd0);
    check({tag, "_fail"}, {31'b0, sync_fail}, 32'd0);
  endtask

  int ok_base, fail_base;

  initial begin
    reset = 1'b1; enable = 1'b0; sample_in_strobe = 1'b0; power_trigger = 1'b0;
    short_preamble_detected = 1'b0; phase_offset_in = 16'h0; long_preamble_detected = 1'b0;
    long_timeout = 32'd160; decode_done = 1'b0; abort = 1'b0;
    tick(); tick();
    check_reset_values("rst");

    // Nominal path with a short pulse inside the reset hold.
    reset = 1'b0; enable = 1'b1;
    ok_base = ok_cnt; fail_base = fail_cnt;
    power_trigger = 1'b1;
    tick();
    check("nom_state_short", {29'b0, state}, 32'd1);
    check("hold_short_reset_1", {31'b0, sync_short_reset}, 32'd1);
    short_preamble_detected = 1'b1; phase_offset_in = 16'hFFFB;
    tick();
    short_preamble_detected = 1'b0;
    check("hold_ignored_state", {29'b0, state}, 32'd1);
    check("hold_short_reset_2", {31'b0, sync_short_reset}, 32'd1);
    tick();
    check("hold_short_reset_off", {31'b0, sync_short_reset}, 32'd0);
    check("hold_short_enable_on", {31'b0, sync_short_enable}, 32'd1);
    short_preamble_detected = 1'b1; phase_offset_in = 16'hFFF7;
    tick();
    short_preamble_detected = 1'b0;
    check("nom_state_long", {29'b0, state}, 32'd2);
    check("nom_phase", {16'b0, phase_offset}, 32'h0000_FFF7);
    check("nom_long_reset", {31'b0, sync_long_reset}, 32'd1);
    tick(); tick();
    check("nom_long_enable", {31'b0, sync_long_enable}, 32'd1);
    strobes(39);
    sample_in_strobe = 1'b1; long_preamble_detected = 1'b1;
    tick();
    sample_in_strobe = 1'b0; long_preamble_detected = 1'b0;
    check("nom_state_decode", {29'b0, state}, 32'd3);
    check("nom_ok", {31'b0, sync_ok}, 32'd1);
    tick();
    check("nom_ok_single", {31'b0, sync_ok}, 32'd0);
    check("dec_long_reset", {31'b0, sync_long_reset}, 32'd0);
    check("dec_short_enable", {31'b0, sync_short_enable}, 32'd0);
    decode_done = 1'b1;
    tick();
    decode_done = 1'b0;
    check("nom_state_idle", {29'b0, state}, 32'd0);
    check("nom_ok_count", 32'(ok_cnt - ok_base), 32'd1);
    check("nom_fail_count", 32'(fail_cnt - fail_base), 32'd0);

    // Timeout on the 160th counted strobe.
    to_long(16'h0011);
    fail_base = fail_cnt;
    strobes(159);
    check("to_state_before", {29'b0, state}, 32'd2);
    check("to_no_fail_yet", 32'(fail_cnt - fail_base), 32'd0);
    sample_in_strobe = 1'b1;
    tick();
    sample_in_strobe = 1'b0;
    check("to_fail", {31'b0, sync_fail}, 32'd1);
    check("to_state_short", {29'b0, state}, 32'd1);
    check("to_short_reset_1", {31'b0, sync_short_reset}, 32'd1);
    tick();
    check("to_fail_single", {31'b0, sync_fail}, 32'd0);
    check("to_short_reset_2", {31'b0, sync_short_reset}, 32'd1);
    tick();
    check("to_short_reset_off", {31'b0, sync_short_reset}, 32'd0);

    // Long detection on the same strobe that would time out.
    short_preamble_detected = 1'b1; phase_offset_in = 16'h0022;
    tick();
    short_preamble_detected = 1'b0;
    tick(); tick();
    strobes(159);
    sample_in_strobe = 1'b1; long_preamble_detected = 1'b1;
    tick();
    sample_in_strobe = 1'b0; long_preamble_detected = 1'b0;
    check("sim_ok", {31'b0, sync_ok}, 32'd1);
    check("sim_fail", {31'b0, sync_fail}, 32'd0);
    check("sim_state", {29'b0, state}, 32'd3);
    decode_done = 1'b1;
    tick();
    decode_done = 1'b0;

    // Abort mid-LONG, coincident with a long detection.
    to_long(16'h004D);
    strobes(20);
    abort = 1'b1; sample_in_strobe = 1'b1; long_preamble_detected = 1'b1;
    tick();
    abort = 1'b0; sample_in_strobe = 1'b0; long_preamble_detected = 1'b0;
    check("abort_state", {29'b0, state}, 32'd0);
    check("abort_ok", {31'b0, sync_ok}, 32'd0);
    check("abort_fail", {31'b0, sync_fail}, 32'd0);
    check("abort_phase", {16'b0, phase_offset}, 32'h0000_004D);

    // Reset mid-LONG dominates every input.
    to_long(16'h0033);
    strobes(5);
    reset = 1'b1; sample_in_strobe = 1'b1; long_preamble_detected = 1'b1;
    tick();
    reset = 1'b0; sample_in_strobe = 1'b0; long_preamble_detected = 1'b0;
    check_reset_values("midrst");

    // Enable gating in LONG; count resumes from the frozen value.
    to_long(16'h0037);
    strobes(50);
    enable = 1'b0; sample_in_strobe = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      check("gate_state", {29'b0, state}, 32'd2);
      check("gate_long_enable", {31'b0, sync_long_enable}, 32'd0);
      check("gate_phase", {16'b0, phase_offset}, 32'h0000_0037);
    end
    enable = 1'b1;
    strobes(109);
    check("gate_state_resume", {29'b0, state}, 32'd2);
    sample_in_strobe = 1'b1;
    tick();
    sample_in_strobe = 1'b0;
    check("gate_fail_at_160", {31'b0, sync_fail}, 32'd1);

    // SHORT: detection beats loss of power; loss of power exits to IDLE.
    tick(); tick();
    power_trigger = 1'b0; sample_in_strobe = 1'b1;
    short_preamble_detected = 1'b1; phase_offset_in = 16'h0044;
    tick();
    short_preamble_detected = 1'b0; sample_in_strobe = 1'b0;
    check("prio_state_long", {29'b0, state}, 32'd2);
    check("prio_phase", {16'b0, phase_offset}, 32'h0000_0044);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    power_trigger = 1'b1;
    tick();
    power_trigger = 1'b0; sample_in_strobe = 1'b1;
    tick();
    sample_in_strobe = 1'b0;
    check("power_exit_state", {29'b0, state}, 32'd0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
